// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_ONE  = 2'd0;
    localparam digit_idx_t IDX_TEN  = 2'd1;
    localparam digit_idx_t IDX_HUN  = 2'd2;
    localparam digit_idx_t IDX_SIGN = 2'd3;

    // Active-low one-hot enable for a digit position.
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] an;
        an = ANODE_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_seg7_decode.sv
// BCD code to active-low seven-segment pattern.
// Codes 10-15 are shown as "E".
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver: sign, hundreds, tens, ones.
// Define SSD_LZ_BLANK_EN for leading-zero blanking and "-0" suppression.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int NUM_DIGITS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       sign,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    generate
        if (NUM_DIGITS != 4) begin : g_bad_digits
            $error("ssd_scan_driver supports exactly 4 digits");
        end
    endgenerate

    localparam logic [REFRESH_BITS-1:0] CNT_ONE =
        {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    digit_idx_t              idx_q, idx_d;
    logic                    h_sign_q, h_sign_d;
    logic [3:0]              h_hun_q, h_hun_d;
    logic [3:0]              h_ten_q, h_ten_d;
    logic [3:0]              h_one_q, h_one_d;
    logic [3:0]              anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;

    logic       wrap;
    logic [3:0] digit_code;
    logic       digit_blank;
    logic [6:0] dec_seg;
    logic       lz_hun;
    logic       lz_ten;
    logic       show_minus;

    assign wrap = &cnt_q;

`ifdef SSD_LZ_BLANK_EN
    assign lz_hun     = (h_hun_q == 4'd0);
    assign lz_ten     = lz_hun && (h_ten_q == 4'd0);
    assign show_minus = h_sign_q && !(lz_ten && (h_one_q == 4'd0));
`else
    assign lz_hun     = 1'b0;
    assign lz_ten     = 1'b0;
    assign show_minus = h_sign_q;
`endif

    always_comb begin
        cnt_d    = cnt_q + CNT_ONE;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        h_sign_d = h_sign_q;
        h_hun_d  = h_hun_q;
        h_ten_d  = h_ten_q;
        h_one_d  = h_one_q;
        if (load) begin
            h_sign_d = sign;
            h_hun_d  = hundreds;
            h_ten_d  = tens;
            h_one_d  = ones;
        end
    end

    always_comb begin
        digit_code  = h_one_q;
        digit_blank = 1'b0;
        unique case (idx_q)
            IDX_ONE: digit_code = h_one_q;
            IDX_TEN: begin
                digit_code  = h_ten_q;
                digit_blank = lz_ten;
            end
            IDX_HUN: begin
                digit_code  = h_hun_q;
                digit_blank = lz_hun;
            end
            default: digit_code = 4'd0;
        endcase
    end

    seg7_decode u_dec (
        .code (digit_code),
        .seg  (dec_seg)
    );

    // Outputs reflect the pre-edge index and held digits.
    always_comb begin
        anode_d      = anode_for(idx_q);
        frame_done_d = wrap && (idx_q == IDX_SIGN);
        if (idx_q == IDX_SIGN) begin
            seg_d = show_minus ? SEG_MINUS : SEG_BLANK;
        end else if (digit_blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= IDX_ONE;
            h_sign_q     <= 1'b0;
            h_hun_q      <= 4'd0;
            h_ten_q      <= 4'd0;
            h_one_q      <= 4'd0;
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            h_sign_q     <= h_sign_d;
            h_hun_q      <= h_hun_d;
            h_ten_q      <= h_ten_d;
            h_one_q      <= h_one_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a 2-bit refresh counter.
// Expected patterns follow SSD_LZ_BLANK_EN when it is defined.
module tb_ssd_scan_driver;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PE = 7'b0000110;
    localparam logic [6:0] PM = 7'b0111111;
    localparam logic [6:0] PB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    logic [3:0] an_tab [4];

    typedef struct packed {
        logic           sgn;
        logic [3:0]     h;
        logic [3:0]     t;
        logic [3:0]     o;
        logic [3:0][6:0] ex;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t zero_v;

    always #5 clk = ~clk;

    ssd_scan_driver #(.REFRESH_BITS(2), .NUM_DIGITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string nm, input logic [3:0] an,
                       input logic [6:0] sg, input logic fd);
        n_cmp++;
        if (anode !== an || seg !== sg || frame_done !== fd || dp !== 1'b1) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got an=%b seg=%b fd=%b dp=%b want an=%b seg=%b fd=%b dp=1",
                     nm, edge_n, anode, seg, frame_done, dp, an, sg, fd);
        end
    endtask

    task automatic chk_fd(input string nm, input logic fd);
        n_cmp++;
        if (frame_done !== fd) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got fd=%b want fd=%b", nm, edge_n, frame_done, fd);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [3:0] h,
                                input logic [3:0] t, input logic [3:0] o,
                                input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        vec_t v;
        v.sgn = s;
        v.h = h;
        v.t = t;
        v.o = o;
        v.ex = {e3, e2, e1, e0};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        an_tab[0] = 4'b1110;
        an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011;
        an_tab[3] = 4'b0111;

        vecs[0] = mk(1'b1, 4'd1, 4'd2, 4'd3, PM, P1, P2, P3);
        vecs[1] = mk(1'b0, 4'd8, 4'd9, 4'd0, PB, P8, P9, P0);
        vecs[2] = mk(1'b0, 4'd4, 4'd5, 4'hC, PB, P4, P5, PE);
        vecs[6] = mk(1'b1, 4'hF, 4'hA, 4'hE, PM, PE, PE, PE);
`ifdef SSD_LZ_BLANK_EN
        vecs[3] = mk(1'b1, 4'd0, 4'd0, 4'd5, PM, PB, PB, P5);
        vecs[4] = mk(1'b1, 4'd0, 4'd0, 4'd0, PB, PB, PB, P0);
        vecs[5] = mk(1'b0, 4'd0, 4'd7, 4'd6, PB, PB, P7, P6);
        zero_v  = mk(1'b0, 4'd0, 4'd0, 4'd0, PB, PB, PB, P0);
`else
        vecs[3] = mk(1'b1, 4'd0, 4'd0, 4'd5, PM, P0, P0, P5);
        vecs[4] = mk(1'b1, 4'd0, 4'd0, 4'd0, PM, P0, P0, P0);
        vecs[5] = mk(1'b0, 4'd0, 4'd7, 4'd6, PB, P0, P7, P6);
        zero_v  = mk(1'b0, 4'd0, 4'd0, 4'd0, PB, P0, P0, P0);
`endif

        rst = 1'b0;
        load = 1'b0;
        sign = 1'b0;
        hundreds = 4'd0;
        tens = 4'd0;
        ones = 4'd0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_state", 4'b1111, PB, 1'b0);

        rst = 1'b1;
        edge_n = 0;
        tick();
        chk("first_after_reset", 4'b1110, P0, 1'b0);

        for (int v = 0; v < NV; v++) begin
            while (edge_n % 16 != 15) tick();
            load = 1'b1;
            sign = vecs[v].sgn;
            hundreds = vecs[v].h;
            tens = vecs[v].t;
            ones = vecs[v].o;
            tick();
            load = 1'b0;
            chk_fd($sformatf("frame_done_v%0d", v), 1'b1);
            for (int k = 0; k < 16; k++) begin
                tick();
                chk($sformatf("scan_v%0d_k%0d", v, k),
                    an_tab[k / 4], vecs[v].ex[k / 4], k == 15);
            end
        end

        // Held value is vecs[6]; change ones mid idx-0 slot.
        while (edge_n % 16 != 1) tick();
        load = 1'b1;
        sign = 1'b1;
        hundreds = 4'hF;
        tens = 4'hA;
        ones = 4'd7;
        tick();
        load = 1'b0;
        chk("midslot_old", 4'b1110, PE, 1'b0);
        tick();
        chk("midslot_new", 4'b1110, P7, 1'b0);

        // Back-to-back loads: the last one wins.
        load = 1'b1;
        ones = 4'd1;
        tick();
        ones = 4'd9;
        tick();
        load = 1'b0;
        tick();
        chk("last_load_wins", 4'b1101, PE, 1'b0);
        while (edge_n % 16 != 0) tick();
        tick();
        chk("last_load_digit0", 4'b1110, P9, 1'b0);

        // Reset in the middle of the idx-2 slot.
        while (edge_n % 16 != 10) tick();
        chk("pre_reset_idx2", 4'b1011, PE, 1'b0);
        rst = 1'b0;
        tick();
        chk("midscan_reset", 4'b1111, PB, 1'b0);
        tick();
        chk("midscan_reset_hold", 4'b1111, PB, 1'b0);
        rst = 1'b1;
        edge_n = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("post_reset_k%0d", k),
                an_tab[k / 4], zero_v.ex[k / 4], k == 15);
        end
        tick();
        chk_fd("post_reset_fd_single", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
